spart_rx: RTL and testbench
===========================

SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16: number of brg_en ticks per bit period.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-006 brg_en  input  1  one-clk-wide oversample tick from the baud generator.
REQ-007 rd_ack  input  1  one-clk-wide host read strobe; clears rda, frame_err and overrun.
REQ-008 rx_data  output  DATA_BITS  last received byte.
REQ-009 rda  output  1  receive data available.
REQ-010 frame_err  output  1  sticky: stop bit sampled low.
REQ-011 overrun  output  1  sticky: a new byte arrived while rda=1.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rxs.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-014 IDLE->START SHALL occur on the first clk where rxs=0; the tick counter clears to 0.
REQ-015 The tick counter SHALL advance only on brg_en.
REQ-016 In START, the bit SHALL be sampled at tick OVERSAMPLE/2-1; rxs=1 there SHALL return to IDLE with no output change (false start).
REQ-017 In START, rxs=0 at that sample SHALL clear the tick counter and enter DATA.
REQ-018 In DATA, bits SHALL be sampled every OVERSAMPLE ticks, LSB first, into a shift register; after DATA_BITS samples the FSM enters STOP.
REQ-019 In STOP, on the mid-bit sample, the shift register SHALL load into rx_data and rda SHALL be set on the next clk.
REQ-020 A stop sample of 1 SHALL return the FSM to IDLE.
REQ-021 A stop sample of 0 SHALL set frame_err, still store the data and set rda, then enter WAIT_IDLE.
REQ-022 WAIT_IDLE SHALL go to IDLE when rxs=1.
REQ-023 A byte completing while rda=1 SHALL overwrite rx_data and set overrun.
REQ-024 If rd_ack coincides with byte completion, completion SHALL win: rda stays 1, overrun stays 0, and the flags are reloaded from the new frame.
REQ-025 rd_ack with rda=0 SHALL be a no-op.
REQ-026 rx_data SHALL hold its value until the next completion; rd_ack does not clear it.

Reset
REQ-027 Asserting rst at any time, including mid-frame, SHALL force the FSM to IDLE.
REQ-028 Reset SHALL clear the counters, the shift register, rx_data, rda, frame_err and overrun.
REQ-029 Reset SHALL set both synchronizer flops to 1.
REQ-030 A partial frame interrupted by reset SHALL never produce rda.

Configuration
REQ-031 With SPART_RX_MAJORITY_EN defined, each bit value SHALL be the 2-of-3 majority of rxs at ticks OVERSAMPLE/2-2, -1 and 0 relative to mid-bit; the decision is taken at the last of the three.
REQ-032 Without SPART_RX_MAJORITY_EN, each bit SHALL be a single sample at mid-bit; no majority hardware is present.

Structure
REQ-033 Package spart_pkg SHALL hold the rx_state_t enum, the default OVERSAMPLE and DATA_BITS constants, and the bit-order definition shared with the transmitter.
REQ-034 The synchronizer SHALL be sub-module spart_sync (2 flops, reset value 1).
REQ-035 The FSM and datapath SHALL reside in spart_rx.

Verification
All scenarios use a 50 MHz clk and brg_en every 27 clk (115200 baud x16).
REQ-036 Frame 0xAB (start, 1,1,0,1,0,1,0,1, stop=1) -> rx_data=0xAB, rda=1, frame_err=0, overrun=0; rd_ack -> rda=0.
REQ-037 Frames 0xCD then 0x50 with no rd_ack -> rx_data=0x50, rda=1, overrun=1.
REQ-038 Frame 0x50 with rd_ack on the completion clk -> rda=1, overrun=0.
REQ-039 Frame 0x3C with stop=0, line held low 2 bit times then high -> frame_err=1, rx_data=0x3C; no second rda while low.
REQ-040 rxd low for 4 ticks -> no rda; a subsequent 0xAB frame is received correctly.
REQ-041 rst asserted mid-bit-4 of 0xAB -> all outputs 0; the next 0xCD frame is received correctly.
REQ-042 With SPART_RX_MAJORITY_EN, a one-tick glitch at mid-bit of each data bit of 0xAB -> rx_data=0xAB.
REQ-043 Without SPART_RX_MAJORITY_EN, the same one-tick mid-bit glitches -> rx_data SHALL equal the glitch-corrupted value.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver state encoding, default frame geometry
// and the serial bit order common to the transmitter and receiver.
package spart_pkg;

    localparam int unsigned SPART_OVERSAMPLE = 16;
    localparam int unsigned SPART_DATA_BITS  = 8;

    // Serial bit order on the line: 1 = LSB is transmitted first.
    localparam bit SPART_LSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage

// File: rtl/spart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so reset release never looks like a start bit.
module spart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Double-register the asynchronous input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: oversampled async serial receive FSM, shift register and
// host status flags (rda, sticky frame_err / overrun).
// Optional: define SPART_RX_MAJORITY_EN to decide each bit by a 2-of-3
// vote over the three ticks ending at mid-bit instead of one sample.
module spart_rx
    import spart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = SPART_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = SPART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 brg_en,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    // Start bit is checked half a bit in; later bits one full bit apart.
    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    rx_state_t            state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 rxs;
    logic                 bit_val_c;
    logic                 sample_c;
    logic                 complete_c;

    spart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

`ifdef SPART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Keep the line value seen on the two previous oversample ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= 2'b11;
        end else if (brg_en) begin
            hist_q <= {hist_q[0], rxs};
        end
    end

    // 2-of-3 vote; the current tick is the last of the three.
    assign bit_val_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
    // Single sample at mid-bit.
    assign bit_val_c = rxs;
`endif

    // Decision tick: mid start bit in START, end of each bit period afterwards.
    assign sample_c   = brg_en && (tick_cnt == ((state == START) ? MID_TICK : LAST_TICK));
    assign complete_c = (state == STOP) && sample_c;

    // Receive FSM with tick/bit counters and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (!rxs) begin
                        state <= START;
                    end
                end
                START: begin
                    if (sample_c) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= bit_val_c ? IDLE : DATA;
                    end else if (brg_en) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (sample_c) begin
                        tick_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        shift_q  <= SPART_LSB_FIRST ? {bit_val_c, shift_q[DATA_BITS-1:1]}
                                                    : {shift_q[DATA_BITS-2:0], bit_val_c};
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else if (brg_en) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (sample_c) begin
                        tick_cnt <= '0;
                        state    <= bit_val_c ? IDLE : WAIT_IDLE;
                    end else if (brg_en) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    tick_cnt <= '0;
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Host-visible data and flags; a completing frame beats a same-cycle read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data   <= '0;
            rda       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (complete_c) begin
            rx_data <= shift_q;
            rda     <= 1'b1;
            if (rd_ack) begin
                frame_err <= ~bit_val_c;
                overrun   <= 1'b0;
            end else begin
                frame_err <= frame_err | ~bit_val_c;
                overrun   <= overrun | rda;
            end
        end else if (rd_ack && rda) begin
            rda       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// Directed + randomized bench for spart_rx with a frame-level reference model.
module tb_spart_rx;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       brg_en;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rda;
    logic       frame_err;
    logic       overrun;

    int n_vec;
    int n_fail;
    int bcnt;

    // Reference model of host-visible state
    logic [7:0] m_data;
    logic       m_rda;
    logic       m_ferr;
    logic       m_ovr;

    spart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .brg_en    (brg_en),
        .rd_ack    (rd_ack),
        .rx_data   (rx_data),
        .rda       (rda),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // 50 MHz clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // One-clk oversample tick every 27 clocks, changed on the falling edge
    initial begin
        bcnt   = 0;
        brg_en = 1'b0;
        forever begin
            @(negedge clk);
            bcnt   = (bcnt == 26) ? 0 : bcnt + 1;
            brg_en = (bcnt == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".rx_data"},   32'(rx_data),   32'(m_data));
        chk({tag, ".rda"},       32'(rda),       32'(m_rda));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
        chk({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
    endtask

    // Model: a frame finished (ack = host read in the same cycle)
    task automatic m_complete(input logic [7:0] d, input logic stop, input bit ack);
        if (ack) begin
            m_ovr  = 1'b0;
            m_ferr = ~stop;
        end else begin
            m_ovr  = m_ovr | m_rda;
            m_ferr = m_ferr | ~stop;
        end
        m_rda  = 1'b1;
        m_data = d;
    endtask

    // Advance to just after the next clock edge that carries an oversample tick
    task automatic wait_tick();
        do @(posedge clk); while (brg_en !== 1'b1);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic host_ack();
        rd_ack = 1'b1;
        @(posedge clk);
        #1;
        rd_ack = 1'b0;
        if (m_rda) begin
            m_rda  = 1'b0;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
    endtask

    // Drive n_ticks oversample periods of a frame: start, 8 data LSB first, stop.
    // glitch inverts each data bit for the one tick period feeding its mid-bit sample.
    // ack_done raises rd_ack on the clock of the stop-bit sample.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit glitch,
                              input bit ack_done, input int n_ticks);
        wait_tick();
        for (int t = 0; t < n_ticks; t++) begin
            int   b;
            logic v;
            b = t / 16;
            if (b == 0)      v = 1'b0;
            else if (b <= 8) v = d[b-1];
            else             v = stop;
            if (glitch && b >= 1 && b <= 8 && (t % 16) == 7) v = ~v;
            rxd = v;
            if (ack_done && t == 151) begin
                repeat (26) @(posedge clk);
                #1;
                rd_ack = 1'b1;
                @(posedge clk);
                #1;
                rd_ack = 1'b0;
            end else begin
                wait_tick();
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       s;
        bit         a;
        logic [7:0] gexp;

        n_vec  = 0;
        n_fail = 0;
        rst    = 1'b0;
        rxd    = 1'b1;
        rd_ack = 1'b0;
        m_data = 8'h00;
        m_rda  = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        chk_all("reset");
        rst = 1'b1;
        idle_ticks(2);

        // Clean frame then host read
        send_frame(8'hAB, 1'b1, 1'b0, 1'b0, 160);
        m_complete(8'hAB, 1'b1, 1'b0);
        chk_all("ab");
        host_ack();
        chk_all("ab_ack");
        host_ack();
        chk_all("ack_noop");

        // Overrun: two frames without a read
        send_frame(8'hCD, 1'b1, 1'b0, 1'b0, 160);
        m_complete(8'hCD, 1'b1, 1'b0);
        send_frame(8'h50, 1'b1, 1'b0, 1'b0, 160);
        m_complete(8'h50, 1'b1, 1'b0);
        chk_all("overrun");
        chk("overrun.flag", 32'(overrun), 32'd1);
        host_ack();
        chk_all("overrun_ack");

        // Read coincides with completion while rda already set
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, 160);
        m_complete(8'h12, 1'b1, 1'b0);
        send_frame(8'h50, 1'b1, 1'b0, 1'b1, 160);
        m_complete(8'h50, 1'b1, 1'b1);
        chk_all("ack_race");
        host_ack();

        // Framing error, line held low two more bit times
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 160);
        m_complete(8'h3C, 1'b0, 1'b0);
        chk_all("ferr");
        host_ack();
        idle_ticks(32);
        chk_all("ferr_low");
        rxd = 1'b1;
        idle_ticks(4);
        chk_all("ferr_idle");

        // False start: 4 ticks low
        wait_tick();
        rxd = 1'b0;
        idle_ticks(4);
        rxd = 1'b1;
        idle_ticks(24);
        chk_all("false_start");
        send_frame(8'hAB, 1'b1, 1'b0, 1'b0, 160);
        m_complete(8'hAB, 1'b1, 1'b0);
        chk_all("after_false");

        // Reset in the middle of data bit 4
        send_frame(8'hAB, 1'b1, 1'b0, 1'b0, 88);
        rst = 1'b0;
        #1;
        m_data = 8'h00;
        m_rda  = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        chk_all("midreset");
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle_ticks(20);
        chk_all("midreset_idle");
        send_frame(8'hCD, 1'b1, 1'b0, 1'b0, 160);
        m_complete(8'hCD, 1'b1, 1'b0);
        chk_all("post_reset");
        host_ack();

        // Mid-bit glitches on every data bit
        send_frame(8'hAB, 1'b1, 1'b1, 1'b0, 160);
`ifdef SPART_RX_MAJORITY_EN
        gexp = 8'hAB;
`else
        gexp = ~8'hAB;
`endif
        m_complete(gexp, 1'b1, 1'b0);
        chk_all("glitch");
        host_ack();

        // Randomized frames
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            s = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
            send_frame(d, s, 1'b0, a, 160);
            m_complete(d, s, a);
            rxd = 1'b1;
            idle_ticks(2);
            chk_all("rand");
            if ($urandom_range(0, 1) == 1) begin
                host_ack();
                chk_all("rand_ack");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
